float_to_fixed: RTL and testbench
=================================

FLOAT_TO_FIXED -- requirements
Module: float_to_fixed

Interface
REQ-001 No parameters; formats fixed: input IEEE-754 binary16, output signed two's-complement Q8.8.
REQ-002 clk  input  1  single clock, all state on rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 in_valid  input  1  float_in valid this cycle.
REQ-005 in_ready  output  1  block can accept; transfer when in_valid && in_ready at rising edge.
REQ-006 float_in  input  16  binary16 operand {sign, exp[4:0], man[9:0]}.
REQ-007 out_valid  output  1  result and flags valid; held until accepted.
REQ-008 out_ready  input  1  consumer accepts; transfer when out_valid && out_ready at rising edge.
REQ-009 fixed_out  output  16  Q8.8 result.
REQ-010 out_ovf  output  1  result saturated.
REQ-011 out_nan  output  1  input was NaN.
REQ-012 out_inexact  output  1  nonzero bits discarded by rounding.

Function
REQ-013 FSM states IDLE, SHIFT, ROUND, OUT; in_ready = 1 only in IDLE; out_valid = 1 only in OUT.
REQ-014 On accept: register sign, exp; M = {hidden,man} (11 bits), hidden = (exp != 0); effective exponent e = max(exp,1).
REQ-015 Shift amount s = e - 17 (fixed = M * 2^s); s > 0 left shift, s < 0 right shift by |s|.
REQ-016 Special cases resolved at accept, IDLE -> OUT directly (out_valid 1 cycle after accept edge): zero (exp=0, man=0) -> 0x0000; NaN (exp=31, man!=0) -> 0x0000, out_nan=1; exp >= 22 (incl. infinity) -> 0x7FFF if sign=0, 0x8000 if sign=1; out_ovf=1 except exact -128.0 (0xD800) where out_ovf=0.
REQ-017 Normal path: IDLE -> SHIFT; SHIFT moves magnitude one bit per cycle for n = |s| cycles (n = 0 passes straight through in one cycle); right shifts update guard bit and sticky OR of all bits shifted past guard.
REQ-018 ROUND: round-to-nearest, ties-to-even on magnitude using guard/sticky; out_inexact = guard | sticky; then negate if sign=1; -> OUT.
REQ-019 Normal-path latency: out_valid rises n + 2 cycles after the accept edge (n = 0..16).
REQ-020 Maximum left shift is 4 (exp=21, magnitude <= 32752); rounding never overflows; normal path never sets out_ovf.
REQ-021 Subnormals use e = 1, hidden = 0, s = -16.
REQ-022 OUT: fixed_out and flags stable while out_valid && !out_ready; on out_ready -> IDLE, in_ready = 1 the following cycle (no same-cycle accept in OUT).
REQ-023 in_valid while busy is ignored; float_in is sampled only at accept.
REQ-024 Flags not defined by a path are 0.

Reset
REQ-025 rst_n low at any time, including mid-SHIFT or in OUT with out_valid high, aborts the conversion immediately: state IDLE, fixed_out = 0x0000, all flags 0, out_valid = 0.
REQ-026 in_ready = 1 in the first cycle after rst_n deasserts; the aborted result is never output.

Structure
REQ-027 Shared package float_fix_pkg holds the state enum, FRAC_BITS = 8, EXP_BIAS = 15, SHIFT_ZERO = 17, OVF_EXP = 22, SAT_POS = 16'h7FFF, SAT_NEG = 16'h8000.
REQ-028 One sub-module fp16_unpack (combinational: sign/exp/M, special-case classification, s) instantiated once; FSM, shifter, rounder in float_to_fixed.

Verification
REQ-029 0x3C00 (1.0), out_ready=1 -> 0x0100, flags 0, out_valid 4 cycles after accept; 0xC000 (-2.0) -> 0xFE00 after 3 cycles.
REQ-030 Rounding: 0x1C00 -> 0x0001 inexact=0; 0x1800 (tie) -> 0x0000 inexact=1; 0x1A00 -> 0x0001 inexact=1.
REQ-031 Saturation/special: 0x5800 -> 0x7FFF ovf=1; 0xD800 -> 0x8000 ovf=0; 0x7C00 -> 0x7FFF ovf=1; 0x7E00 -> 0x0000 nan=1; each 1 cycle after accept.
REQ-032 Backpressure: 0x4000 with out_ready low 5 cycles -> fixed_out=0x0200 held stable, in_ready=0 throughout; in_valid pulses with 0x3C00 during this time not accepted.
REQ-033 Reset mid-SHIFT on subnormal 0x0001 (cycle 5 of 16) -> outputs 0, in_ready=1 after release; next 0x3C00 -> 0x0100.
REQ-034 Back-to-back: in_valid held with 0x3C00 then 0xC000, out_ready=1 -> two results in order, one IDLE cycle between them.

Source files
------------

// File: rtl/float_fix_pkg.sv
// Shared types and constants for the binary16 -> Q8.8 converter.
package float_fix_pkg;

    localparam int FRAC_BITS  = 8;
    localparam int MAN_BITS   = 10;
    localparam int EXP_BIAS   = 15;
    // fixed = M * 2^(e - SHIFT_ZERO), with M the 11-bit significand as an integer
    localparam int SHIFT_ZERO = EXP_BIAS + MAN_BITS - FRAC_BITS;
    localparam int OVF_EXP    = 22;

    localparam logic [15:0] SAT_POS = 16'h7FFF;
    localparam logic [15:0] SAT_NEG = 16'h8000;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        ROUND,
        OUT
    } state_t;

    typedef struct packed {
        logic        sign;
        logic [10:0] mant;
        logic        special;
        logic [15:0] special_value;
        logic        special_ovf;
        logic        special_nan;
        logic        shift_left;
        logic [4:0]  shift_amt;
    } unpack_t;

endpackage

// File: rtl/fp16_unpack.sv
// Combinational decode of a binary16 operand: significand, shift direction/amount
// and early resolution of zero, NaN and out-of-range inputs.
module fp16_unpack
    import float_fix_pkg::*;
(
    input  logic [15:0] float_in,
    output unpack_t     unp
);

    logic [4:0]        exp_f;
    logic [9:0]        man_f;
    logic [4:0]        exp_eff;
    logic signed [6:0] shift_s;
    logic              is_zero;
    logic              is_nan;
    logic              is_big;
    logic              is_min_neg;

    always_comb begin
        exp_f      = float_in[14:10];
        man_f      = float_in[9:0];
        exp_eff    = (exp_f == 5'd0) ? 5'd1 : exp_f;
        shift_s    = $signed({2'b00, exp_eff}) - $signed(7'(SHIFT_ZERO));
        is_zero    = (exp_f == 5'd0) && (man_f == 10'd0);
        is_nan     = (exp_f == 5'd31) && (man_f != 10'd0);
        is_big     = !is_nan && (exp_f >= 5'(OVF_EXP));
        // -128.0 is the one out-of-range-exponent value Q8.8 can represent exactly
        is_min_neg = float_in[15] && (exp_f == 5'(OVF_EXP)) && (man_f == 10'd0);

        unp.sign          = float_in[15];
        unp.mant          = {exp_f != 5'd0, man_f};
        unp.special       = is_zero | is_nan | is_big;
        unp.special_value = is_big ? (float_in[15] ? SAT_NEG : SAT_POS) : 16'h0000;
        unp.special_ovf   = is_big && !is_min_neg;
        unp.special_nan   = is_nan;
        unp.shift_left    = !shift_s[6];
        unp.shift_amt     = shift_s[6] ? 5'(-shift_s) : 5'(shift_s);
    end

endmodule

// File: rtl/float_to_fixed.sv
// Serial binary16 -> signed Q8.8 converter: one shift bit per cycle, then
// round-to-nearest-even and sign application, with valid/ready on both sides.
module float_to_fixed
    import float_fix_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] float_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] fixed_out,
    output logic        out_ovf,
    output logic        out_nan,
    output logic        out_inexact
);

    state_t      state_reg;
    state_t      state_next;
    unpack_t     unp;
    logic        accept;

    logic        sign_reg;
    logic        left_reg;
    logic        guard_reg;
    logic        sticky_reg;
    logic [4:0]  count_reg;
    logic [15:0] mag_reg;
    logic [15:0] fixed_reg;
    logic        ovf_reg;
    logic        nan_reg;
    logic        inexact_reg;

    logic        round_up;
    logic [15:0] mag_rounded;

    fp16_unpack u_unpack (
        .float_in (float_in),
        .unp      (unp)
    );

    assign accept = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept) state_next = unp.special ? OUT : SHIFT;
            SHIFT:   if (count_reg == 5'd0) state_next = ROUND;
            ROUND:   state_next = OUT;
            OUT:     if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_reg == IDLE);
        out_valid = (state_reg == OUT);
    end

    // Left shifts are always exact, so guard/sticky stay clear on that path.
    always_comb begin
        round_up    = guard_reg & (sticky_reg | mag_reg[0]);
        mag_rounded = mag_reg + {15'd0, round_up};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sign_reg    <= 1'b0;
            left_reg    <= 1'b0;
            guard_reg   <= 1'b0;
            sticky_reg  <= 1'b0;
            count_reg   <= 5'd0;
            mag_reg     <= 16'd0;
            fixed_reg   <= 16'd0;
            ovf_reg     <= 1'b0;
            nan_reg     <= 1'b0;
            inexact_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        sign_reg   <= unp.sign;
                        left_reg   <= unp.shift_left;
                        count_reg  <= unp.shift_amt;
                        mag_reg    <= {5'd0, unp.mant};
                        guard_reg  <= 1'b0;
                        sticky_reg <= 1'b0;
                        if (unp.special) begin
                            fixed_reg   <= unp.special_value;
                            ovf_reg     <= unp.special_ovf;
                            nan_reg     <= unp.special_nan;
                            inexact_reg <= 1'b0;
                        end
                    end
                end
                SHIFT: begin
                    if (count_reg != 5'd0) begin
                        count_reg <= count_reg - 5'd1;
                        if (left_reg) begin
                            mag_reg <= mag_reg << 1;
                        end else begin
                            mag_reg    <= mag_reg >> 1;
                            guard_reg  <= mag_reg[0];
                            sticky_reg <= sticky_reg | guard_reg;
                        end
                    end
                end
                ROUND: begin
                    fixed_reg   <= sign_reg ? (16'd0 - mag_rounded) : mag_rounded;
                    ovf_reg     <= 1'b0;
                    nan_reg     <= 1'b0;
                    inexact_reg <= guard_reg | sticky_reg;
                end
                default: ;
            endcase
        end
    end

    assign fixed_out   = fixed_reg;
    assign out_ovf     = ovf_reg;
    assign out_nan     = nan_reg;
    assign out_inexact = inexact_reg;

endmodule

// File: tb/tb_float_to_fixed.sv
// Scoreboard-driven bench for float_to_fixed: expected results are queued when a
// conversion is launched and compared when the result appears.
module tb_float_to_fixed;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] float_in = 16'h0000;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] fixed_out;
    logic        out_ovf;
    logic        out_nan;
    logic        out_inexact;

    typedef struct {
        logic [15:0] val;
        logic        ovf;
        logic        nan;
        logic        inx;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   fails  = 0;

    float_to_fixed dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .float_in    (float_in),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .fixed_out   (fixed_out),
        .out_ovf     (out_ovf),
        .out_nan     (out_nan),
        .out_inexact (out_inexact)
    );

    always #5 clk = ~clk;

    // Reference: exact integer scaling with remainder-based round-half-even.
    function automatic exp_t model(input logic [15:0] f);
        exp_t r;
        int ex, man, m, s, k, q, rem, half;
        r.val = 16'h0000; r.ovf = 1'b0; r.nan = 1'b0; r.inx = 1'b0; r.lat = 0;
        ex  = int'(f[14:10]);
        man = int'(f[9:0]);
        if (ex == 0 && man == 0) return r;
        if (ex == 31 && man != 0) begin
            r.nan = 1'b1;
            return r;
        end
        if (ex >= 22) begin
            if (f[15] && ex == 22 && man == 0) r.val = 16'h8000;
            else begin
                r.val = f[15] ? 16'h8000 : 16'h7FFF;
                r.ovf = 1'b1;
            end
            return r;
        end
        m = ((ex != 0) ? 1024 : 0) + man;
        s = ((ex == 0) ? 1 : ex) - 17;
        if (s >= 0) begin
            q     = m << s;
            r.lat = s + 2;
        end else begin
            k    = -s;
            q    = m >> k;
            rem  = m - (q << k);
            half = 1 << (k - 1);
            if (rem > half || (rem == half && (q % 2) == 1)) q++;
            r.inx = (rem != 0);
            r.lat = k + 2;
        end
        r.val = f[15] ? 16'(-q) : 16'(q);
        return r;
    endfunction

    // Launches one conversion, waits for its result and consumes it if out_ready.
    task automatic run_one(input logic [15:0] f, output logic [15:0] v, output logic o,
                           output logic n, output logic x, output int lat, output bit ok);
        int w;
        ok = 1'b0; lat = 0; v = 16'h0; o = 1'b0; n = 1'b0; x = 1'b0; w = 0;
        while (!in_ready && w < 50) begin
            @(posedge clk); #1; w++;
        end
        if (!in_ready) return;
        in_valid = 1'b1; float_in = f;
        @(posedge clk); #1;
        in_valid = 1'b0;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1; lat++;
        end
        if (!out_valid) return;
        v = fixed_out; o = out_ovf; n = out_nan; x = out_inexact; ok = 1'b1;
        if (out_ready) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || fixed_out !== 16'h0 || {out_ovf, out_nan, out_inexact} !== 3'b000) begin
            fails++;
            $display("FAIL reset_state: got valid=%b val=%h flags=%b%b%b, want 0 0000 000",
                     out_valid, fixed_out, out_ovf, out_nan, out_inexact);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_ready: got in_ready=%b, want 1", in_ready);
        end else $display("reset: outputs clear, in_ready=1");
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        logic [15:0] tin [2] = '{16'h3C00, 16'hC000};
        exp_t tex [2] = '{'{16'h0100, 1'b0, 1'b0, 1'b0, 4}, '{16'hFE00, 1'b0, 1'b0, 1'b0, 3}};
        logic [15:0] v; logic o, n, x; int lat; bit ok; exp_t e;
        for (int i = 0; i < 2; i++) begin
            sb.push_back(tex[i]);
            run_one(tin[i], v, o, n, x, lat, ok);
            e = sb.pop_front();
            checks++;
            if (!ok || v !== e.val || {o, n, x} !== {e.ovf, e.nan, e.inx} || lat != e.lat) begin
                fails++;
                $display("FAIL basic %h: got val=%h flags=%b%b%b lat=%0d ok=%b, want val=%h flags=%b%b%b lat=%0d",
                         tin[i], v, o, n, x, lat, ok, e.val, e.ovf, e.nan, e.inx, e.lat);
            end else $display("basic %h -> %h lat=%0d", tin[i], v, lat);
        end
    endtask

    task automatic test_rounding();
        logic [15:0] tin [4] = '{16'h1C00, 16'h1800, 16'h1A00, 16'h0001};
        exp_t tex [4] = '{'{16'h0001, 1'b0, 1'b0, 1'b0, 12}, '{16'h0000, 1'b0, 1'b0, 1'b1, 13},
                          '{16'h0001, 1'b0, 1'b0, 1'b1, 13}, '{16'h0000, 1'b0, 1'b0, 1'b1, 18}};
        logic [15:0] v; logic o, n, x; int lat; bit ok; exp_t e;
        for (int i = 0; i < 4; i++) begin
            sb.push_back(tex[i]);
            run_one(tin[i], v, o, n, x, lat, ok);
            e = sb.pop_front();
            checks++;
            if (!ok || v !== e.val || {o, n, x} !== {e.ovf, e.nan, e.inx} || lat != e.lat) begin
                fails++;
                $display("FAIL round %h: got val=%h flags=%b%b%b lat=%0d ok=%b, want val=%h flags=%b%b%b lat=%0d",
                         tin[i], v, o, n, x, lat, ok, e.val, e.ovf, e.nan, e.inx, e.lat);
            end else $display("round %h -> %h inexact=%b lat=%0d", tin[i], v, x, lat);
        end
    endtask

    task automatic test_special();
        logic [15:0] tin [7] = '{16'h5800, 16'hD800, 16'h7C00, 16'h7E00, 16'h0000, 16'hFC00, 16'h57FF};
        exp_t tex [7] = '{'{16'h7FFF, 1'b1, 1'b0, 1'b0, 0}, '{16'h8000, 1'b0, 1'b0, 1'b0, 0},
                          '{16'h7FFF, 1'b1, 1'b0, 1'b0, 0}, '{16'h0000, 1'b0, 1'b1, 1'b0, 0},
                          '{16'h0000, 1'b0, 1'b0, 1'b0, 0}, '{16'h8000, 1'b1, 1'b0, 1'b0, 0},
                          '{16'h7FF0, 1'b0, 1'b0, 1'b0, 6}};
        logic [15:0] v; logic o, n, x; int lat; bit ok; exp_t e;
        for (int i = 0; i < 7; i++) begin
            sb.push_back(tex[i]);
            run_one(tin[i], v, o, n, x, lat, ok);
            e = sb.pop_front();
            checks++;
            if (!ok || v !== e.val || {o, n, x} !== {e.ovf, e.nan, e.inx} || lat != e.lat) begin
                fails++;
                $display("FAIL special %h: got val=%h flags=%b%b%b lat=%0d ok=%b, want val=%h flags=%b%b%b lat=%0d",
                         tin[i], v, o, n, x, lat, ok, e.val, e.ovf, e.nan, e.inx, e.lat);
            end else $display("special %h -> %h ovf=%b nan=%b lat=%0d", tin[i], v, o, n, lat);
        end
    endtask

    task automatic test_random();
        logic [15:0] f, v; logic o, n, x; int lat; bit ok; exp_t e;
        for (int i = 0; i < 30; i++) begin
            f = {1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), 10'($urandom_range(0, 1023))};
            sb.push_back(model(f));
            run_one(f, v, o, n, x, lat, ok);
            e = sb.pop_front();
            checks++;
            if (!ok || v !== e.val || {o, n, x} !== {e.ovf, e.nan, e.inx} || lat != e.lat) begin
                fails++;
                $display("FAIL random %h: got val=%h flags=%b%b%b lat=%0d ok=%b, want val=%h flags=%b%b%b lat=%0d",
                         f, v, o, n, x, lat, ok, e.val, e.ovf, e.nan, e.inx, e.lat);
            end else $display("random %h -> %h flags=%b%b%b lat=%0d", f, v, o, n, x, lat);
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] v; logic o, n, x; int lat; bit ok; exp_t e;
        out_ready = 1'b0;
        sb.push_back('{16'h0200, 1'b0, 1'b0, 1'b0, 3});
        run_one(16'h4000, v, o, n, x, lat, ok);
        e = sb.pop_front();
        checks++;
        if (!ok || v !== e.val || {o, n, x} !== {e.ovf, e.nan, e.inx} || lat != e.lat) begin
            fails++;
            $display("FAIL bp_result: got val=%h flags=%b%b%b lat=%0d ok=%b, want val=%h lat=%0d",
                     v, o, n, x, lat, ok, e.val, e.lat);
        end else $display("backpressure 4000 -> %h lat=%0d", v, lat);
        for (int i = 0; i < 5; i++) begin
            in_valid = (i % 2 == 0); float_in = 16'h3C00;
            checks++;
            if (out_valid !== 1'b1 || fixed_out !== 16'h0200 || in_ready !== 1'b0) begin
                fails++;
                $display("FAIL bp_hold cycle %0d: got valid=%b val=%h in_ready=%b, want 1 0200 0",
                         i, out_valid, fixed_out, in_ready);
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL bp_release: got valid=%b in_ready=%b, want 0 1", out_valid, in_ready);
        end
        repeat (6) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL bp_ghost: got valid=%b in_ready=%b, want 0 1 (busy in_valid must be ignored)",
                     out_valid, in_ready);
        end else $display("backpressure: held 5 cycles, busy requests ignored");
    endtask

    task automatic test_reset_mid_shift();
        logic [15:0] v; logic o, n, x; int lat; bit ok; exp_t e; int seen;
        in_valid = 1'b1; float_in = 16'h0001;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || fixed_out !== 16'h0 || {out_ovf, out_nan, out_inexact} !== 3'b000) begin
            fails++;
            $display("FAIL rst_shift_clear: got valid=%b val=%h flags=%b%b%b, want 0 0000 000",
                     out_valid, fixed_out, out_ovf, out_nan, out_inexact);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL rst_shift_ready: got in_ready=%b, want 1", in_ready);
        end
        seen = 0;
        for (int i = 0; i < 25; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        checks++;
        if (seen != 0) begin
            fails++;
            $display("FAIL rst_shift_abort: got %0d valid cycles, want 0", seen);
        end
        sb.push_back('{16'h0100, 1'b0, 1'b0, 1'b0, 4});
        run_one(16'h3C00, v, o, n, x, lat, ok);
        e = sb.pop_front();
        checks++;
        if (!ok || v !== e.val || {o, n, x} !== {e.ovf, e.nan, e.inx} || lat != e.lat) begin
            fails++;
            $display("FAIL rst_shift_next: got val=%h lat=%0d ok=%b, want val=%h lat=%0d", v, lat, ok, e.val, e.lat);
        end else $display("reset mid-shift aborted, then 3c00 -> %h", v);

        out_ready = 1'b0;
        sb.push_back('{16'h7FFF, 1'b1, 1'b0, 1'b0, 0});
        run_one(16'h7C00, v, o, n, x, lat, ok);
        e = sb.pop_front();
        checks++;
        if (!ok || v !== e.val || {o, n, x} !== {e.ovf, e.nan, e.inx} || lat != e.lat) begin
            fails++;
            $display("FAIL rst_out_pre: got val=%h ovf=%b lat=%0d ok=%b, want val=%h ovf=1 lat=0", v, o, lat, ok, e.val);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || fixed_out !== 16'h0 || out_ovf !== 1'b0) begin
            fails++;
            $display("FAIL rst_out_clear: got valid=%b val=%h ovf=%b, want 0 0000 0", out_valid, fixed_out, out_ovf);
        end else $display("reset in OUT cleared pending result");
        @(posedge clk); #1;
        rst_n = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        int lat; exp_t e;
        sb.push_back('{16'h0100, 1'b0, 1'b0, 1'b0, 4});
        sb.push_back('{16'hFE00, 1'b0, 1'b0, 1'b0, 3});
        in_valid = 1'b1; float_in = 16'h3C00;
        @(posedge clk); #1;
        float_in = 16'hC000;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1; lat++;
        end
        e = sb.pop_front();
        checks++;
        if (out_valid !== 1'b1 || fixed_out !== e.val || lat != e.lat) begin
            fails++;
            $display("FAIL b2b_first: got valid=%b val=%h lat=%0d, want 1 %h lat=%0d", out_valid, fixed_out, lat, e.val, e.lat);
        end else $display("b2b 3c00 -> %h lat=%0d", fixed_out, lat);
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL b2b_idle: got valid=%b in_ready=%b, want 0 1", out_valid, in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1; lat++;
        end
        e = sb.pop_front();
        checks++;
        if (out_valid !== 1'b1 || fixed_out !== e.val || lat != e.lat) begin
            fails++;
            $display("FAIL b2b_second: got valid=%b val=%h lat=%0d, want 1 %h lat=%0d", out_valid, fixed_out, lat, e.val, e.lat);
        end else $display("b2b c000 -> %h lat=%0d", fixed_out, lat);
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_rounding();
        test_special();
        test_random();
        test_backpressure();
        test_reset_mid_shift();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", checks, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, got %0d checks", checks);
        $fatal(1, "watchdog");
    end

endmodule
